// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer: launches the CNN layer blocks one at a time over their
// shared level start/done handshake. It masks stale done levels left over from
// the previous inference and guards every stage with a programmable watchdog.
// Optional feature macro: CNN_SEQ_PERF_CNT_EN (busy-cycle counter on run_cycles_o).
module cnn_layer_sequencer #(
  parameter int NUM_STAGES = 6,
  parameter int STAGE_W    = 3,
  parameter int TIMEOUT_W  = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run_req_i,
  input  logic                  abort_i,
  input  logic [TIMEOUT_W-1:0]  timeout_cycles_i,
  input  logic [NUM_STAGES-1:0] stage_done_i,
  output logic [NUM_STAGES-1:0] stage_start_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [STAGE_W-1:0]    cur_stage_o,
  output logic [STAGE_W-1:0]    err_stage_o,
  output logic [31:0]           run_cycles_o
);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAIT, S_GAP, S_ERROR} state_t;

  state_t                  state_q, state_d;
  logic [NUM_STAGES-1:0]   start_q, start_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic [STAGE_W-1:0]      cur_q, cur_d;
  logic [STAGE_W-1:0]      err_stg_q, err_stg_d;
  logic [TIMEOUT_W-1:0]    wdog_q, wdog_d;

  logic                    cur_done;
  logic [NUM_STAGES-1:0]   cur_onehot;
  logic                    last_stage;
  logic                    wdog_hit;
  logic                    run_acc;

  // Select the done level of the current stage and its one-hot start pattern.
  always_comb begin
    cur_done   = 1'b0;
    cur_onehot = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (cur_q == STAGE_W'(i)) begin
        cur_done      = stage_done_i[i];
        cur_onehot[i] = 1'b1;
      end
    end
  end

  assign last_stage = (cur_q == STAGE_W'(NUM_STAGES - 1));
  // A zero limit disables the watchdog; the limit is live, not latched.
  assign wdog_hit   = (timeout_cycles_i != '0) && (wdog_q == timeout_cycles_i);
  // run_req is only honoured when not running, and abort always beats it.
  assign run_acc    = run_req_i && !abort_i && (state_q == S_IDLE || state_q == S_ERROR);

  // Next-state and registered-output logic for the stage scheduler.
  always_comb begin
    state_d   = state_q;
    start_d   = start_q;
    busy_d    = busy_q;
    done_d    = done_q;
    error_d   = error_q;
    cur_d     = cur_q;
    err_stg_d = err_stg_q;
    wdog_d    = wdog_q;
    if (abort_i) begin
      state_d = S_IDLE;
      start_d = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      error_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_ERROR: begin
          if (run_acc) begin
            state_d   = S_ARM;
            start_d   = NUM_STAGES'(1);
            busy_d    = 1'b1;
            done_d    = 1'b0;
            error_d   = 1'b0;
            err_stg_d = '0;
            cur_d     = '0;
            wdog_d    = '0;
          end
        end
        S_ARM: begin
          // Hold start until the layer drops any done left from the last run.
          wdog_d = wdog_q + 1'b1;
          if (wdog_hit) begin
            state_d   = S_ERROR;
            start_d   = '0;
            busy_d    = 1'b0;
            error_d   = 1'b1;
            err_stg_d = cur_q;
          end else if (!cur_done) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          // A done seen on the watchdog's final cycle still counts as success.
          wdog_d = wdog_q + 1'b1;
          if (cur_done) begin
            state_d = S_GAP;
            start_d = '0;
          end else if (wdog_hit) begin
            state_d   = S_ERROR;
            start_d   = '0;
            busy_d    = 1'b0;
            error_d   = 1'b1;
            err_stg_d = cur_q;
          end
        end
        S_GAP: begin
          if (last_stage) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_ARM;
            cur_d   = cur_q + 1'b1;
            start_d = cur_onehot << 1;
            wdog_d  = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
          start_d = '0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      start_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      cur_q     <= '0;
      err_stg_q <= '0;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      cur_q     <= cur_d;
      err_stg_q <= err_stg_d;
      wdog_q    <= wdog_d;
    end
  end

  assign stage_start_o = start_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign error_o       = error_q;
  assign cur_stage_o   = cur_q;
  assign err_stage_o   = err_stg_q;

`ifdef CNN_SEQ_PERF_CNT_EN
  logic [31:0] rc_q, rc_d;

  // Busy-cycle counter: cleared on an accepted run, saturating, frozen when idle.
  always_comb begin
    rc_d = rc_q;
    if (run_acc) begin
      rc_d = '0;
    end else if (busy_q && (rc_q != '1)) begin
      rc_d = rc_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rc_q <= '0;
    end else begin
      rc_q <= rc_d;
    end
  end

  assign run_cycles_o = rc_q;
`else
  assign run_cycles_o = '0;
`endif

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Bench for cnn_layer_sequencer: layer models with configurable latency and
// stale-done behaviour, a timeline reference model, table and random runs.
module tb_cnn_layer_sequencer;

  localparam int NS  = 3;
  localparam int SW  = 2;
  localparam int TW  = 24;
  localparam int VW  = NS + 3 + 2 * SW + 32;
  localparam int BIG = 1000000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          run_req = 1'b0;
  logic          abort = 1'b0;
  logic [TW-1:0] timeout_cycles = '0;
  logic [NS-1:0] stage_done;
  logic [NS-1:0] dut_start;
  logic          dut_busy, dut_done, dut_err;
  logic [SW-1:0] dut_cur, dut_estg;
  logic [31:0]   dut_rc;

  cnn_layer_sequencer #(.NUM_STAGES(NS), .STAGE_W(SW), .TIMEOUT_W(TW)) dut (
    .clk(clk), .reset(reset), .run_req_i(run_req), .abort_i(abort),
    .timeout_cycles_i(timeout_cycles), .stage_done_i(stage_done),
    .stage_start_o(dut_start), .busy_o(dut_busy), .done_o(dut_done),
    .error_o(dut_err), .cur_stage_o(dut_cur), .err_stage_o(dut_estg),
    .run_cycles_o(dut_rc)
  );

  always #5 clk = ~clk;

  // ---------------- layer models ----------------
  // A layer begins work on the first edge it sees start high after having seen
  // it low, drops a held done after 'ack' edges, raises done after 'lat' edges
  // (lat=0: never) and holds done until it is started again.
  typedef struct packed {
    logic        active;
    logic        seen_low;
    logic        done;
    logic [15:0] cnt;
  } lyr_t;

  lyr_t lyr [NS];
  int   lat_a [NS];
  int   ack_a [NS];
  bit   init_done [NS];
  int   reinit_gen = 1;
  int   seen_gen = 0;

  function automatic lyr_t layer_step(input lyr_t c, input logic start, input int lat, input int ack);
    lyr_t n;
    n = c;
    if (!start) n.seen_low = 1'b1;
    else if (c.seen_low && !c.active) begin
      n.active = 1'b1; n.seen_low = 1'b0; n.cnt = '0;
    end
    if (n.active) begin
      n.cnt = 16'(n.cnt + 1);
      if (int'(n.cnt) == ack) n.done = 1'b0;
      if (lat != 0 && int'(n.cnt) == lat) begin n.done = 1'b1; n.active = 1'b0; end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    if (seen_gen != reinit_gen) begin
      seen_gen <= reinit_gen;
      for (int i = 0; i < NS; i++) lyr[i] <= '{active: 1'b0, seen_low: 1'b1, done: init_done[i], cnt: 16'd0};
    end else begin
      for (int i = 0; i < NS; i++) lyr[i] <= layer_step(lyr[i], dut_start[i], lat_a[i], ack_a[i]);
    end
  end

  always_comb begin
    stage_done = '0;
    for (int i = 0; i < NS; i++) stage_done[i] = lyr[i].done;
  end

  // ---------------- scenarios and reference timeline ----------------
  typedef struct {
    logic [NS-1:0][7:0] lat;
    logic [NS-1:0][7:0] ack;
    logic [NS-1:0]      stale;
    int                 T;
    int                 exp_end;
    int                 exp_err;
  } scn_t;

  int n_checks = 0;
  int n_err = 0;
  int s_rel [NS];
  int m_rel [NS];
  int err_k;
  int end_rel;
  int first_rel;

  function automatic scn_t mk(input int l0, input int l1, input int l2, input int a0, input int a1,
                              input int a2, input logic [NS-1:0] stl, input int t, input int ee, input int er);
    scn_t s;
    s.lat = {8'(l2), 8'(l1), 8'(l0)};
    s.ack = {8'(a2), 8'(a1), 8'(a0)};
    s.stale = stl; s.T = t; s.exp_end = ee; s.exp_err = er;
    return s;
  endfunction

  // Timeline relative to the run_req edge (rel 0): stage k starts at s, its
  // done is sampled at m = s+lat+1, the next stage starts at m+1 and the run
  // ends at m_last+1. The watchdog fires at s+T+1 unless done is sampled first.
  task automatic plan(input scn_t sc);
    int t, m;
    t = 0; err_k = -1; end_rel = 0;
    for (int k = 0; k < NS; k++) begin s_rel[k] = BIG; m_rel[k] = BIG; end
    for (int k = 0; k < NS && err_k < 0; k++) begin
      s_rel[k] = t;
      m = (sc.lat[k] == 0) ? BIG : t + int'(sc.lat[k]) + 1;
      if (sc.T != 0 && t + sc.T + 1 < m) begin
        err_k = k; end_rel = t + sc.T + 1;
      end else begin
        m_rel[k] = m; t = m + 1;
      end
    end
    if (err_k < 0) end_rel = t;
  endtask

  function automatic logic [VW-1:0] expect_at(input int r);
    logic [NS-1:0] st; logic b, d, e; logic [SW-1:0] cur, es; logic [31:0] rc;
    st = '0; b = 1'b0; d = 1'b0; e = 1'b0; cur = '0; es = '0;
    if (r >= end_rel) begin
      if (err_k >= 0) begin e = 1'b1; cur = SW'(err_k); es = SW'(err_k); end
      else begin d = 1'b1; cur = SW'(NS - 1); end
    end else begin
      b = 1'b1;
      for (int k = 0; k < NS; k++) begin
        if (r >= s_rel[k]) begin
          cur = SW'(k);
          st  = (r < m_rel[k]) ? (NS'(1) << k) : '0;
        end
      end
    end
`ifdef CNN_SEQ_PERF_CNT_EN
    rc = 32'((r < end_rel) ? r : end_rel);
`else
    rc = '0;
`endif
    return {st, b, d, e, cur, es, rc};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {dut_start, dut_busy, dut_done, dut_err, dut_cur, dut_estg, dut_rc};
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Load layer parameters, re-initialise the layers and pulse run_req.
  task automatic launch(input scn_t sc);
    @(negedge clk);
    for (int k = 0; k < NS; k++) begin
      lat_a[k] = int'(sc.lat[k]); ack_a[k] = int'(sc.ack[k]); init_done[k] = sc.stale[k];
    end
    timeout_cycles = TW'(sc.T);
    reinit_gen++;
    plan(sc);
    @(negedge clk);
    run_req = 1'b1;
    @(negedge clk);
    run_req = 1'b0;
    first_rel = -1;
  endtask

  // Compare every output against the timeline for rel 0..nrel-1.
  task automatic follow(input int id, input int nrel);
    for (int r = 0; r < nrel; r++) begin
      check($sformatf("s%0d_r%0d", id, r), 64'(dut_vec()), 64'(expect_at(r)));
      if (first_rel < 0 && (dut_done || dut_err)) first_rel = r;
      @(negedge clk);
    end
  endtask

  task automatic run_scn(input int id, input scn_t sc, input bit tbl_chk);
    launch(sc);
    follow(id, end_rel + 3);
    if (tbl_chk) begin
      check($sformatf("s%0d_end", id), 64'(first_rel), 64'(sc.exp_end));
      check($sformatf("s%0d_err", id), 64'(dut_err), 64'(sc.exp_err >= 0));
      if (sc.exp_err >= 0) check($sformatf("s%0d_estg", id), 64'(dut_estg), 64'(sc.exp_err));
`ifdef CNN_SEQ_PERF_CNT_EN
      check($sformatf("s%0d_rc", id), 64'(dut_rc), 64'(sc.exp_end));
`else
      check($sformatf("s%0d_rc", id), 64'(dut_rc), 64'd0);
`endif
    end
  endtask

  scn_t tbl [7];
  scn_t rs;
  int   lv;

  initial begin
    // lat0..2, ack0..2, stale, timeout, expected end rel, expected error stage
    tbl[0] = mk(10, 20, 5, 1, 1, 1, 3'b000, 0, 41, -1);    // nominal
    tbl[1] = mk(8, 8, 8, 4, 4, 4, 3'b111, 0, 30, -1);      // stale done on all layers
    tbl[2] = mk(10, 0, 5, 1, 1, 1, 3'b000, 100, 113, 1);   // stage 1 never done
    tbl[3] = mk(10, 10, 10, 1, 1, 1, 3'b000, 10, 36, -1);  // done on watchdog match
    tbl[4] = mk(10, 10, 10, 1, 1, 1, 3'b000, 9, 10, 0);    // watchdog one cycle early
    tbl[5] = mk(12, 12, 12, 10, 1, 1, 3'b001, 5, 6, 0);    // timeout while still in ARM
    tbl[6] = mk(4, 3, 6, 2, 1, 3, 3'b101, 0, 19, -1);      // short stages after an error

    repeat (3) @(negedge clk);
    check("reset_vals", 64'(dut_vec()), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 64'(dut_vec()), 64'd0);

    for (int i = 0; i < 7; i++) run_scn(i, tbl[i], 1'b1);

    // abort in stage 2 together with run_req
    launch(tbl[0]);
    follow(50, 36);
    abort = 1'b1; run_req = 1'b1;
    @(negedge clk);
    abort = 1'b0; run_req = 1'b0;
    check("abort_start", 64'(dut_start), 64'd0);
    check("abort_busy", 64'(dut_busy), 64'd0);
    check("abort_done", 64'(dut_done), 64'd0);
    check("abort_error", 64'(dut_err), 64'd0);
`ifdef CNN_SEQ_PERF_CNT_EN
    check("abort_rc", 64'(dut_rc), 64'd37);
`else
    check("abort_rc", 64'(dut_rc), 64'd0);
`endif
    @(negedge clk);
    check("abort_ignored_start", 64'(dut_start), 64'd0);
    check("abort_ignored_busy", 64'(dut_busy), 64'd0);
    run_scn(51, tbl[0], 1'b1);

    // asynchronous reset while stage 1 is waiting for done
    launch(tbl[0]);
    follow(60, 20);
    #2 reset = 1'b1;
    #1 check("async_reset_vals", 64'(dut_vec()), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_scn(61, tbl[0], 1'b1);

    // randomized layer timing against the timeline model
    for (int i = 0; i < 24; i++) begin
      for (int k = 0; k < NS; k++) begin
        lv = int'($urandom_range(3, 25));
        rs.lat[k] = 8'(lv);
        rs.ack[k] = 8'($urandom_range(1, lv - 1));
        rs.stale[k] = 1'($urandom_range(0, 1));
      end
      rs.T = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(3, 40));
      rs.exp_end = 0; rs.exp_err = -1;
      run_scn(100 + i, rs, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/cnn_layer_sequencer.md
# cnn_layer_sequencer

Top-level scheduler for the CNN inference pipeline (conv, pool and fc layer blocks). It launches each layer in a fixed order using the level start/done handshake all layer blocks share, and releases start between layers. It masks stale `done` levels left over from a previous inference and guards every stage with a programmable watchdog. It sits between the host/run control and the per-layer `start`/`done` pins.

## Interface
Parameters:
- `NUM_STAGES`, default 6: number of sequenced layers; stage 0 runs first.
- `STAGE_W`, default 3: width of stage index; must satisfy 2^STAGE_W ≥ NUM_STAGES.
- `TIMEOUT_W`, default 24: width of the watchdog counter and limit.

Ports:
- Clock and reset: reset reset, asynchronous, active-high; clock clk.
- `run_req`, in, 1: request one inference; sampled only in IDLE, ERROR or DONE-hold.
- `abort`, in, 1: synchronous kill; returns to IDLE from any state.
- `timeout_cycles`, in, TIMEOUT_W: per-stage watchdog limit; 0 disables the watchdog.
- `stage_done`, in, NUM_STAGES: level done from each layer.
- `stage_start`, out, NUM_STAGES: one-hot-or-zero level start to each layer.
- `busy`, out, 1: high in ARM, WAIT and GAP.
- `done`, out, 1: high after all stages complete; held until the next accepted `run_req` or `abort`.
- `error`, out, 1: watchdog expired; held until the next accepted `run_req` or `abort`.
- `cur_stage`, out, STAGE_W: index of the stage currently or last launched.
- `err_stage`, out, STAGE_W: stage that timed out; valid while `error`=1.
- `run_cycles`, out, 32: see Configuration.

## Operation
- States: IDLE, ARM, WAIT, GAP, ERROR. All outputs are registered.
- IDLE to ARM: taken on `run_req`=1. This clears `done`, `error` and `err_stage`, and sets `cur_stage`=0.
- ARM: `stage_start[cur_stage]`=1.
  - Waits until `stage_done[cur_stage]` is sampled 0. This discards a stale done from the previous run, because layers hold done high until they see start again.
  - Moves to WAIT on the cycle it samples done=0.
- WAIT: `stage_start[cur_stage]`=1. Moves to GAP when `stage_done[cur_stage]` is sampled 1.
- GAP: all `stage_start`=0 for exactly one cycle.
  - If `cur_stage`=NUM_STAGES-1: set `done`=1 and go to IDLE.
  - Otherwise: increment `cur_stage` and go to ARM.
- Watchdog:
  - Counter resets to 0 on every entry to ARM and increments each cycle in ARM and WAIT.
  - If `timeout_cycles`≠0 and the counter equals `timeout_cycles`, go to ERROR: `error`=1, `err_stage`=`cur_stage`, all starts 0.
  - If done is sampled 1 in WAIT on the same cycle the watchdog matches, done wins.
- ERROR: all starts 0. Stays in ERROR until `run_req`, which behaves as from IDLE.
- `abort` has the highest priority, including over same-cycle `run_req`. From any state it goes to IDLE with all starts 0 and `done`=0, `error`=0.
- `stage_done` bits of non-current stages are ignored.
- `timeout_cycles` is sampled every cycle; changing it mid-stage takes effect immediately.

## Timing
- Reset values:
  - `stage_start`=0, `busy`=0, `done`=0, `error`=0.
  - `cur_stage`=0, `err_stage`=0, `run_cycles`=0.
  - state=IDLE.
- `run_req` sampled at edge n gives `stage_start[0]`=1 and `busy`=1 from n+1.
- Done for a stage sampled at edge m:
  - that stage's start=0 from m+1 (GAP);
  - next stage's start=1 from m+2.
- Last stage done sampled at edge m gives `done`=1 and `busy`=0 from m+2.
- Minimum ARM dwell is 1 cycle, so a layer always sees start high for at least 2 cycles.
- Start is never high for two stages simultaneously.
- Start-low gap between consecutive stages is exactly 1 cycle.
- Between runs, start stays low for at least 1 cycle, which satisfies the layers' wait-for-start-low return.
- Timeout: with limit T, ERROR is entered T+1 edges after ARM entry, unless done is sampled first.
- Reset mid-run: asynchronous return to reset values; no partial-stage state survives.

## Configuration
- Macro: `CNN_SEQ_PERF_CNT_EN`.
- Defined:
  - `run_cycles` counts cycles with `busy`=1 since the last accepted `run_req`.
  - Saturates at 0xFFFF_FFFF and holds its value after done, error or abort.
  - Cleared to 0 on `run_req` acceptance.
- Undefined: `run_cycles` is tied to 0 and no counter is synthesized. The port list is unchanged.

## Test plan
- Nominal run: NUM_STAGES=3, stage models with 10/20/5-cycle latency, `timeout_cycles`=0, `run_req` pulse at edge 5.
  - Starts go one-hot in order 0,1,2, each with a 1-cycle gap.
  - `done`=1 at the predicted cycle.
  - `run_cycles`=41 with the macro defined (0 when undefined).
- Stale done: all stage models hold done=1 from a prior run, then `run_req` is issued.
  - Sequencer stays in ARM until each done drops.
  - No stage is skipped.
- Watchdog: stage 1 model never asserts done, `timeout_cycles`=100.
  - `error`=1 and `err_stage`=1 at ARM entry + 101 edges.
  - All starts 0.
  - `run_req` afterwards restarts from stage 0.
- Race: stage 0 done is sampled 1 in WAIT on the exact cycle the watchdog counter equals the limit.
  - No error; sequencer proceeds to stage 1.
- Abort: `abort` in the middle of stage 2, same cycle as `run_req`.
  - Next cycle: IDLE, all starts 0, `done`=0, `error`=0.
  - `run_req` is ignored that cycle.
- Async reset during WAIT of stage 1.
  - All outputs return to reset values immediately.
  - The next run starts from stage 0.
